// File: rtl/mmio_pkg.sv
// Address map constants, UART state encoding and a word-address compare helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mmio_pkg;

   localparam logic [31:0] ADDR_GPIO      = 32'h1000_0000;
   localparam logic [31:0] ADDR_UART_DAT  = 32'h1000_0004;
   localparam logic [31:0] ADDR_UART_STAT = 32'h1000_0008;
   localparam logic [31:0] ADDR_TMR_CNT   = 32'h1000_000C;
   localparam logic [31:0] ADDR_TMR_CMP   = 32'h1000_0010;
   localparam logic [31:0] ADDR_IRQ_STAT  = 32'h1000_0014;

   localparam logic [31:0] WORD_MASK      = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      UART_IDLE  = 2'd0,
      UART_START = 2'd1,
      UART_DATA  = 2'd2,
      UART_STOP  = 2'd3
   } uart_state_t;

   // Byte offset bits are dropped: every register is a full word.
   function automatic logic adr_match(input logic [31:0] adr, input logic [31:0] reg_adr);
      return (adr & WORD_MASK) == reg_adr;
   endfunction

endpackage

// File: rtl/mmio_bus_uart_tx.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit.
// Latency: line drops on the edge that accepts start; frame is 10*CLKS_PER_BIT cycles.
// Backpressure: start is accepted only in IDLE; starts while busy are dropped, no queueing.
module uart_tx
   import mmio_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] data,
   output logic       tx,
   output logic       busy
);

   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);

   uart_state_t   r_state;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_bit;
   logic [7:0]    r_shift;
   logic          r_tx;

   // Frame sequencer; the line level is registered so it changes only on bit boundaries.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= UART_IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_tx    <= 1'b1;
      end else begin
         case (r_state)
            UART_IDLE: begin
               r_tx <= 1'b1;
               if (start) begin
                  r_shift <= data;
                  r_cnt   <= '0;
                  r_bit   <= '0;
                  r_tx    <= 1'b0;
                  r_state <= UART_START;
               end
            end
            UART_START: begin
               if (r_cnt == LAST_CLK) begin
                  r_cnt   <= '0;
                  r_tx    <= r_shift[0];
                  r_state <= UART_DATA;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            UART_DATA: begin
               if (r_cnt == LAST_CLK) begin
                  r_cnt <= '0;
                  if (r_bit == 3'd7) begin
                     r_tx    <= 1'b1;
                     r_state <= UART_STOP;
                  end else begin
                     r_bit   <= r_bit + 3'd1;
                     r_shift <= {1'b0, r_shift[7:1]};
                     r_tx    <= r_shift[1];
                  end
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            UART_STOP: begin
               if (r_cnt == LAST_CLK) begin
                  r_cnt   <= '0;
                  r_state <= UART_IDLE;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: r_state <= UART_IDLE;
         endcase
      end
   end

   assign tx   = r_tx;
   assign busy = (r_state != UART_IDLE);

endmodule

// File: rtl/mmio_bus.sv
// Word-addressed MMIO slave: RAM, GPIO, UART transmitter, free-running timer with compare irq.
// Latency: reads are combinational from data_adr; writes take effect on the strobed clk edge.
// Backpressure: none; the bus never stalls, UART writes while busy are silently dropped.
module mmio_bus
   import mmio_pkg::*;
#(
   parameter int MEM_WORDS    = 256,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] data_adr,
   input  logic [31:0] WriteData,
   input  logic        write_enable,
   output logic [31:0] ReadData,
   output logic [7:0]  gpio_out,
   output logic        uart_tx,
   output logic        timer_irq
);

   localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

   logic [31:0]   r_mem [MEM_WORDS];
   logic [7:0]    r_gpio;
   logic [31:0]   r_count;
   logic [31:0]   r_compare;
   logic          r_pending;

   logic          w_ram_hit;
   logic          w_gpio_hit;
   logic          w_udat_hit;
   logic          w_ustat_hit;
   logic          w_cnt_hit;
   logic          w_cmp_hit;
   logic          w_irq_hit;
   logic [AW-1:0] w_ram_idx;
   logic          w_match;
   logic          w_clear;
   logic          w_uart_busy;

   assign w_ram_hit   = (data_adr[31:2] < 30'(MEM_WORDS));
   assign w_ram_idx   = data_adr[AW+1:2];
   assign w_gpio_hit  = adr_match(data_adr, ADDR_GPIO);
   assign w_udat_hit  = adr_match(data_adr, ADDR_UART_DAT);
   assign w_ustat_hit = adr_match(data_adr, ADDR_UART_STAT);
   assign w_cnt_hit   = adr_match(data_adr, ADDR_TMR_CNT);
   assign w_cmp_hit   = adr_match(data_adr, ADDR_TMR_CMP);
   assign w_irq_hit   = adr_match(data_adr, ADDR_IRQ_STAT);

   assign w_match = (r_count == r_compare);
   assign w_clear = write_enable & w_irq_hit & WriteData[0];

   // RAM store; contents survive reset by design.
   always_ff @(posedge clk) begin
      if (write_enable && w_ram_hit) begin
         r_mem[w_ram_idx] <= WriteData;
      end
   end

   // GPIO output register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_gpio <= '0;
      end else if (write_enable && w_gpio_hit) begin
         r_gpio <= WriteData[7:0];
      end
   end

   // Timer: free-running count, compare register, sticky pending where a match beats a clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count   <= '0;
         r_compare <= 32'hFFFF_FFFF;
         r_pending <= 1'b0;
      end else begin
         if (write_enable && w_cnt_hit) begin
            r_count <= WriteData;
         end else begin
            r_count <= r_count + 32'd1;
         end
         if (write_enable && w_cmp_hit) begin
            r_compare <= WriteData;
         end
         r_pending <= w_match | (r_pending & ~w_clear);
      end
   end

   uart_tx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_uart (
      .clk  (clk),
      .reset(reset),
      .start(write_enable & w_udat_hit),
      .data (WriteData[7:0]),
      .tx   (uart_tx),
      .busy (w_uart_busy)
   );

   // Read mux; unmapped addresses and the UART data register read as zero.
   always_comb begin
      ReadData = '0;
      if (w_ram_hit) begin
         ReadData = r_mem[w_ram_idx];
      end else if (w_gpio_hit) begin
         ReadData = {24'd0, r_gpio};
      end else if (w_ustat_hit) begin
         ReadData = {31'd0, w_uart_busy};
      end else if (w_cnt_hit) begin
         ReadData = r_count;
      end else if (w_cmp_hit) begin
         ReadData = r_compare;
      end else if (w_irq_hit) begin
         ReadData = {31'd0, r_pending};
      end
   end

   assign gpio_out  = r_gpio;
   assign timer_irq = r_pending;

endmodule

// File: tb/tb_mmio_bus.sv
// Self-checking bench for mmio_bus: directed scenarios plus randomized traffic vs a reference model.
// Inputs change just after the falling edge; outputs are compared away from the rising edge.
module tb_mmio_bus;
   import mmio_pkg::*;

   localparam int MEMW  = 256;
   localparam int CPB   = 4;
   localparam int FRAME = 10 * CPB;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] data_adr;
   logic [31:0] WriteData;
   logic        write_enable;
   logic [31:0] ReadData;
   logic [7:0]  gpio_out;
   logic        uart_tx;
   logic        timer_irq;

   mmio_bus #(.MEM_WORDS(MEMW), .CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .reset(reset), .data_adr(data_adr), .WriteData(WriteData),
      .write_enable(write_enable), .ReadData(ReadData), .gpio_out(gpio_out),
      .uart_tx(uart_tx), .timer_irq(timer_irq)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: architectural state only, advanced once per rising edge.
   logic [31:0] m_mem  [MEMW];
   bit          m_memv [MEMW];
   logic [7:0]  m_gpio;
   logic [31:0] m_cnt, m_cmp;
   bit          m_pend;
   int          m_cyc;      // rising edges since reset release
   int          m_fs;       // m_cyc value of the cycle a frame started
   logic [7:0]  m_fbyte;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit m_busy();
      int e = m_cyc - m_fs;
      return (e >= 0) && (e < FRAME);
   endfunction

   // Line level from the position within the frame: bit slot 0 start, 1..8 data, 9 stop.
   function automatic logic m_tx();
      int e = m_cyc - m_fs;
      int slot;
      if (!m_busy()) return 1'b1;
      slot = e / CPB;
      if (slot == 0) return 1'b0;
      if (slot <= 8) return m_fbyte[slot-1];
      return 1'b1;
   endfunction

   task automatic model_reset();
      m_gpio = '0; m_cnt = '0; m_cmp = 32'hFFFF_FFFF; m_pend = 1'b0;
      m_cyc = 0; m_fs = -1000; m_fbyte = '0;
   endtask

   function automatic bit model_read(input logic [31:0] adr, output logic [31:0] exp);
      logic [31:0] a = adr & 32'hFFFF_FFFC;
      int w = int'(adr >> 2);
      exp = '0;
      if (adr[31:2] < 30'(MEMW)) begin
         exp = m_mem[w];
         return m_memv[w];
      end
      case (a)
         ADDR_GPIO:      exp = {24'd0, m_gpio};
         ADDR_UART_STAT: exp = {31'd0, m_busy()};
         ADDR_TMR_CNT:   exp = m_cnt;
         ADDR_TMR_CMP:   exp = m_cmp;
         ADDR_IRQ_STAT:  exp = {31'd0, m_pend};
         default:        exp = '0;
      endcase
      return 1'b1;
   endfunction

   task automatic model_edge(input bit we, input logic [31:0] adr, input logic [31:0] wd);
      logic [31:0] a = adr & 32'hFFFF_FFFC;
      bit match = (m_cnt == m_cmp);
      bit clr   = we && (a == ADDR_IRQ_STAT) && wd[0];
      bit was_busy = m_busy();
      m_pend = match || (m_pend && !clr);
      if (we && a == ADDR_TMR_CNT) m_cnt = wd;
      else                         m_cnt = m_cnt + 32'd1;
      if (we && a == ADDR_TMR_CMP) m_cmp = wd;
      if (we && a == ADDR_GPIO)    m_gpio = wd[7:0];
      if (we && adr[31:2] < 30'(MEMW)) begin
         m_mem[int'(adr >> 2)]  = wd;
         m_memv[int'(adr >> 2)] = 1'b1;
      end
      m_cyc++;
      if (we && a == ADDR_UART_DAT && !was_busy) begin
         m_fs = m_cyc;
         m_fbyte = wd[7:0];
      end
   endtask

   // One bus cycle, entered just after a falling edge and left on the next falling edge.
   task automatic step(input bit we, input logic [31:0] adr, input logic [31:0] wd);
      logic [31:0] exp;
      write_enable = we; data_adr = adr; WriteData = wd;
      #1;
      if (model_read(adr, exp)) chk("read_data", ReadData, exp);
      @(posedge clk);
      model_edge(we, adr, wd);
      @(negedge clk);
      chk("gpio_out", {24'd0, gpio_out}, {24'd0, m_gpio});
      chk("uart_tx", 32'(uart_tx), 32'(m_tx()));
      chk("timer_irq", 32'(timer_irq), 32'(m_pend));
   endtask

   task automatic reset_checks(input string tag);
      data_adr = ADDR_UART_STAT; write_enable = 1'b0; WriteData = '0;
      #1;
      chk({tag, "_uart_tx"}, 32'(uart_tx), 32'd1);
      chk({tag, "_busy"}, ReadData, 32'd0);
      chk({tag, "_gpio"}, {24'd0, gpio_out}, 32'd0);
      chk({tag, "_irq"}, 32'(timer_irq), 32'd0);
   endtask

   function automatic logic [31:0] rand_adr();
      logic [31:0] a;
      case ($urandom_range(0, 9))
         0, 1, 2: a = 32'($urandom_range(0, MEMW - 1)) << 2;
         3: a = ADDR_GPIO;
         4: a = ADDR_UART_DAT;
         5: a = ADDR_UART_STAT;
         6: a = ADDR_TMR_CNT;
         7: a = ADDR_TMR_CMP;
         8: a = ADDR_IRQ_STAT;
         default: case ($urandom_range(0, 3))
            0: a = 32'h1000_0018;
            1: a = 32'(MEMW) << 2;
            2: a = 32'h2000_0000;
            default: a = 32'hFFFF_FFFC;
         endcase
      endcase
      return a | 32'($urandom_range(0, 3));
   endfunction

   initial begin
      int busy_cnt;
      int n;
      for (int i = 0; i < MEMW; i++) m_memv[i] = 1'b0;
      reset = 1'b1; data_adr = '0; WriteData = '0; write_enable = 1'b0;
      #2 reset = 1'b0;
      model_reset();
      @(negedge clk);
      reset_checks("rst_init");
      @(negedge clk);
      reset = 1'b1;

      // Reset values of the timer block
      step(0, ADDR_TMR_CNT, 0);
      step(0, ADDR_TMR_CMP, 0);
      step(0, ADDR_IRQ_STAT, 0);
      step(0, ADDR_UART_STAT, 0);

      // Word access ignores the byte offset
      step(1, 32'h0000_0010, 32'hDEAD_BEEF);
      data_adr = 32'h0000_0013; write_enable = 1'b0; #1;
      chk("ram_offset_read", ReadData, 32'hDEAD_BEEF);
      step(0, 32'h0000_0013, 0);
      step(1, 32'(MEMW - 1) << 2, 32'h1234_5678);
      step(0, 32'(MEMW - 1) << 2 | 32'd2, 0);

      // GPIO keeps only the low byte; unmapped space reads zero
      step(1, ADDR_GPIO, 32'h0000_01A5);
      chk("gpio_value", {24'd0, gpio_out}, 32'h0000_00A5);
      step(0, 32'h2000_0000, 0);
      data_adr = 32'h2000_0000; #1;
      chk("unmapped_read", ReadData, 32'd0);
      step(1, 32'(MEMW) << 2, 32'hFFFF_FFFF);
      step(0, ADDR_UART_DAT, 0);

      // UART frame of 0x55 with an overlapping write ten cycles in
      busy_cnt = 0;
      step(1, ADDR_UART_DAT, 32'h55);
      data_adr = ADDR_UART_STAT; write_enable = 1'b0; #1;
      busy_cnt += int'(ReadData[0]);
      for (int i = 1; i < FRAME + 5; i++) begin
         if (i == 10) step(1, ADDR_UART_DAT, 32'hFF);
         else         step(0, ADDR_UART_STAT, 0);
         data_adr = ADDR_UART_STAT; write_enable = 1'b0; #1;
         busy_cnt += int'(ReadData[0]);
      end
      chk("uart_busy_cycles", 32'(busy_cnt), 32'(FRAME));

      // Timer wrap: count 1 is reached on the third edge after the load, pending one edge later
      step(1, ADDR_TMR_CMP, 32'h0000_0001);
      step(1, ADDR_TMR_CNT, 32'hFFFF_FFFE);
      n = 0;
      for (int i = 0; i < 10 && !timer_irq; i++) begin
         step(0, ADDR_IRQ_STAT, 0);
         n++;
      end
      chk("irq_rise_delay", 32'(n), 32'd4);
      step(0, ADDR_IRQ_STAT, 0);

      // Clear coincident with a fresh match: set wins
      step(1, ADDR_TMR_CMP, 32'd20);
      step(1, ADDR_TMR_CNT, 32'd17);
      for (int i = 0; i < 10 && m_cnt != 32'd20; i++) step(0, ADDR_TMR_CNT, 0);
      step(1, ADDR_IRQ_STAT, 32'd1);
      chk("irq_set_wins", 32'(timer_irq), 32'd1);
      step(1, ADDR_IRQ_STAT, 32'd1);
      chk("irq_cleared", 32'(timer_irq), 32'd0);

      // Randomized traffic across the whole map
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), rand_adr(), $urandom());
      end

      // Reset in the middle of a frame
      for (int i = 0; i < FRAME; i++) step(0, ADDR_UART_STAT, 0);
      step(1, ADDR_GPIO, 32'h3C);
      step(1, ADDR_UART_DAT, 32'h00);
      for (int i = 1; i < 15; i++) step(0, ADDR_UART_STAT, 0);
      chk("pre_reset_tx_low", 32'(uart_tx), 32'd0);
      reset = 1'b0;
      model_reset();
      reset_checks("rst_mid");
      @(negedge clk);
      reset_checks("rst_hold");
      reset = 1'b1;
      step(0, ADDR_TMR_CNT, 0);
      step(0, ADDR_TMR_CNT, 0);
      step(0, ADDR_UART_STAT, 0);
      step(0, ADDR_GPIO, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
